// File: rtl/matrix_transmitter.sv
// Serial transmitter for the 2x4 cell matrix: frames one cell, a row, a column or the whole matrix.
// Define TX_TWO_STOP_EN to send two stop bits instead of one.
module matrix_transmitter #(
   parameter int W   = 8,
   parameter int DIV = 3,
   parameter int PAR = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         we,
   input  logic         row,
   input  logic [1:0]   col,
   input  logic [W-1:0] w_cell,
   input  logic [3:0]   action,
   input  logic         start,
   output logic         tx,
   output logic         busy,
   output logic         done
);

`ifdef TX_TWO_STOP_EN
   localparam int StopCyc = 2 * DIV;
`else
   localparam int StopCyc = DIV;
`endif
   localparam int CntW = (StopCyc > 1) ? $clog2(StopCyc) : 1;
   localparam int BitW = (W > 1) ? $clog2(W) : 1;
   localparam logic [CntW-1:0] BitLast  = CntW'(DIV - 1);
   localparam logic [CntW-1:0] StopLast = CntW'(StopCyc - 1);
   localparam logic [BitW-1:0] DataLast = BitW'(W - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   state_t          state_q, state_d;
   logic [CntW-1:0] divCnt_q, divCnt_d;
   logic [BitW-1:0] bitIdx_q, bitIdx_d;
   logic [2:0]      cellIdx_q, cellIdx_d;
   logic            row_q, row_d;
   logic [1:0]      col_q, col_d;
   logic [3:0]      action_q, action_d;
   logic            parity_q, parity_d;
   logic            done_q, done_d;

   logic [W-1:0]    mat_q [2][4];

   logic            curRow;
   logic [1:0]      curCol;
   logic [2:0]      lastCell;
   logic            curBit;
   logic            accept;
   logic            bitEnd;

   // The matrix is only writable while idle, so it stays stable for the whole frame.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 4; c++) begin
               mat_q[r][c] <= '0;
            end
         end
      end else if (we && (state_q == ST_IDLE)) begin
         mat_q[row][col] <= w_cell;
      end
   end

   // Map the running cell index onto matrix coordinates for the latched action.
   always_comb begin
      curRow   = row_q;
      curCol   = col_q;
      lastCell = 3'd7;
      case (action_q)
         4'd6: lastCell = 3'd0;
         4'd7: begin
            curCol   = cellIdx_q[1:0];
            lastCell = 3'd3;
         end
         4'd8: begin
            curRow   = cellIdx_q[0];
            lastCell = 3'd1;
         end
         default: begin
            curRow = cellIdx_q[2];
            curCol = cellIdx_q[1:0];
         end
      endcase
   end

   assign curBit = mat_q[curRow][curCol][bitIdx_q];
   assign accept = start && (action >= 4'd6) && (action <= 4'd9);
   assign bitEnd = (divCnt_q == BitLast);

   always_comb begin
      state_d   = state_q;
      divCnt_d  = divCnt_q;
      bitIdx_d  = bitIdx_q;
      cellIdx_d = cellIdx_q;
      row_d     = row_q;
      col_d     = col_q;
      action_d  = action_q;
      parity_d  = parity_q;
      done_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d   = ST_START;
               divCnt_d  = '0;
               bitIdx_d  = '0;
               cellIdx_d = '0;
               row_d     = row;
               col_d     = col;
               action_d  = action;
               parity_d  = 1'b0;
            end
         end
         ST_START: begin
            if (bitEnd) begin
               divCnt_d = '0;
               state_d  = ST_DATA;
            end else begin
               divCnt_d = divCnt_q + 1'b1;
            end
         end
         ST_DATA: begin
            if (bitEnd) begin
               divCnt_d = '0;
               parity_d = parity_q ^ curBit;
               if (bitIdx_q == DataLast) begin
                  bitIdx_d = '0;
                  if (cellIdx_q == lastCell) begin
                     state_d = (PAR != 0) ? ST_PARITY : ST_STOP;
                  end else begin
                     cellIdx_d = cellIdx_q + 3'd1;
                  end
               end else begin
                  bitIdx_d = bitIdx_q + 1'b1;
               end
            end else begin
               divCnt_d = divCnt_q + 1'b1;
            end
         end
         ST_PARITY: begin
            if (bitEnd) begin
               divCnt_d = '0;
               state_d  = ST_STOP;
            end else begin
               divCnt_d = divCnt_q + 1'b1;
            end
         end
         ST_STOP: begin
            if (divCnt_q == StopLast) begin
               divCnt_d = '0;
               state_d  = ST_IDLE;
               done_d   = 1'b1;
            end else begin
               divCnt_d = divCnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         divCnt_q  <= '0;
         bitIdx_q  <= '0;
         cellIdx_q <= '0;
         row_q     <= 1'b0;
         col_q     <= '0;
         action_q  <= '0;
         parity_q  <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         divCnt_q  <= divCnt_d;
         bitIdx_q  <= bitIdx_d;
         cellIdx_q <= cellIdx_d;
         row_q     <= row_d;
         col_q     <= col_d;
         action_q  <= action_d;
         parity_q  <= parity_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      tx = 1'b1;
      case (state_q)
         ST_START:  tx = 1'b0;
         ST_DATA:   tx = curBit;
         ST_PARITY: tx = (PAR == 2) ? ~parity_q : parity_q;
         default:   tx = 1'b1;
      endcase
   end

   assign busy = (state_q != ST_IDLE);
   assign done = done_q;

endmodule

// File: tb/tb_matrix_transmitter.sv
// Bench for matrix_transmitter: three instances (no/even/odd parity) share stimulus and are
// compared cycle by cycle against a frame model built from the matrix contents.
module tb_matrix_transmitter;

   localparam int W   = 8;
   localparam int DIV = 3;
`ifdef TX_TWO_STOP_EN
   localparam int NSTOP = 2;
`else
   localparam int NSTOP = 1;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         we = 1'b0;
   logic         row = 1'b0;
   logic [1:0]   col = 2'd0;
   logic [W-1:0] wCell = '0;
   logic [3:0]   action = 4'd0;
   logic         start = 1'b0;
   logic [2:0]   txV;
   logic [2:0]   busyV;
   logic [2:0]   doneV;

   int           vectorCount = 0;
   int           missCount = 0;
   logic [W-1:0] model [2][4];
   bit           dataBits[$];

   always #5 clk = ~clk;

   matrix_transmitter #(.W(W), .DIV(DIV), .PAR(0)) dut0 (
      .clk(clk), .rst(rst), .we(we), .row(row), .col(col), .w_cell(wCell),
      .action(action), .start(start), .tx(txV[0]), .busy(busyV[0]), .done(doneV[0]));

   matrix_transmitter #(.W(W), .DIV(DIV), .PAR(1)) dut1 (
      .clk(clk), .rst(rst), .we(we), .row(row), .col(col), .w_cell(wCell),
      .action(action), .start(start), .tx(txV[1]), .busy(busyV[1]), .done(doneV[1]));

   matrix_transmitter #(.W(W), .DIV(DIV), .PAR(2)) dut2 (
      .clk(clk), .rst(rst), .we(we), .row(row), .col(col), .w_cell(wCell),
      .action(action), .start(start), .tx(txV[2]), .busy(busyV[2]), .done(doneV[2]));

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectorCount++;
      if (got !== exp) begin
         missCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Collect the data bits of the selected cells, row-major, each cell LSB first.
   task automatic buildData(input int act, input int r, input int c);
      bit sel;
      dataBits.delete();
      for (int rr = 0; rr < 2; rr++) begin
         for (int cc = 0; cc < 4; cc++) begin
            sel = (act == 9) || (act == 7 && rr == r) || (act == 8 && cc == c) ||
                  (act == 6 && rr == r && cc == c);
            if (sel) begin
               for (int b = 0; b < W; b++) dataBits.push_back(model[rr][cc][b]);
            end
         end
      end
   endtask

   function automatic int frameBits(input int par);
      return 1 + dataBits.size() + ((par != 0) ? 1 : 0) + NSTOP;
   endfunction

   function automatic bit expBit(input int par, input int idx);
      bit x;
      if (idx == 0) return 1'b0;
      if (idx - 1 < dataBits.size()) return dataBits[idx - 1];
      if (par != 0 && idx == dataBits.size() + 1) begin
         x = 1'b0;
         foreach (dataBits[i]) x = x ^ dataBits[i];
         return (par == 2) ? ~x : x;
      end
      return 1'b1;
   endfunction

   function automatic void clearModel();
      for (int r = 0; r < 2; r++) for (int c = 0; c < 4; c++) model[r][c] = '0;
   endfunction

   task automatic writeCell(input int r, input int c, input int v);
      we = 1'b1;
      row = r[0];
      col = c[1:0];
      wCell = v[W-1:0];
      @(negedge clk);
      we = 1'b0;
      model[r][c] = v[W-1:0];
   endtask

   // Launch one frame and compare tx/busy/done of all three instances every cycle.
   task automatic applyStimulus(input int act, input int r, input int c, input bit doWrite,
                                input int wv, input int injectCycle, input string tag);
      int  lenK;
      int  window;
      bit  badTx [3];
      bit  badBusy [3];
      bit  badDone [3];
      logic expTx;
      start = 1'b1;
      action = act[3:0];
      row = r[0];
      col = c[1:0];
      if (doWrite) begin
         we = 1'b1;
         wCell = wv[W-1:0];
         model[r][c] = wv[W-1:0];
      end
      @(negedge clk);
      start = 1'b0;
      we = 1'b0;
      buildData(act, r, c);
      window = frameBits(1) * DIV + 4;
      for (int k = 0; k < 3; k++) begin
         badTx[k] = 1'b0;
         badBusy[k] = 1'b0;
         badDone[k] = 1'b0;
      end
      for (int cyc = 0; cyc < window; cyc++) begin
         for (int k = 0; k < 3; k++) begin
            lenK = frameBits(k) * DIV;
            expTx = (cyc < lenK) ? expBit(k, cyc / DIV) : 1'b1;
            if (!badTx[k]) begin
               checkOutput($sformatf("%s dut%0d tx cyc%0d", tag, k, cyc), txV[k], expTx);
               badTx[k] = (txV[k] !== expTx);
            end
            if (!badBusy[k]) begin
               checkOutput($sformatf("%s dut%0d busy cyc%0d", tag, k, cyc), busyV[k], cyc < lenK);
               badBusy[k] = (busyV[k] !== (cyc < lenK));
            end
            if (!badDone[k]) begin
               checkOutput($sformatf("%s dut%0d done cyc%0d", tag, k, cyc), doneV[k], cyc == lenK);
               badDone[k] = (doneV[k] !== (cyc == lenK));
            end
         end
         if (cyc == injectCycle) begin
            we = 1'b1;
            wCell = 8'h3C;
            start = 1'b1;
            action = 4'd6;
            row = 1'($urandom_range(0, 1));
            col = 2'($urandom_range(0, 3));
         end else begin
            we = 1'b0;
            start = 1'b0;
         end
         @(negedge clk);
      end
   endtask

   task automatic checkIdle(input string tag);
      for (int k = 0; k < 3; k++) begin
         checkOutput($sformatf("%s dut%0d tx", tag, k), txV[k], 1);
         checkOutput($sformatf("%s dut%0d busy", tag, k), busyV[k], 0);
         checkOutput($sformatf("%s dut%0d done", tag, k), doneV[k], 0);
      end
   endtask

   initial begin
      int nW;
      int act;
      int r;
      int c;
      clearModel();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkIdle("reset");
      applyStimulus(9, 0, 0, 1'b0, 0, -1, "allzero");

      writeCell(1, 2, 8'hA5);
      applyStimulus(6, 1, 2, 1'b0, 0, -1, "cellA5");

      writeCell(0, 0, 8'h01);
      writeCell(0, 1, 8'h02);
      writeCell(0, 2, 8'h04);
      writeCell(0, 3, 8'h00);
      applyStimulus(7, 0, 0, 1'b0, 0, -1, "row0");

      writeCell(0, 3, 8'hFF);
      writeCell(1, 3, 8'h0F);
      applyStimulus(8, 0, 3, 1'b0, 0, -1, "col3");

      applyStimulus(9, 0, 0, 1'b0, 0, 20, "interfere");
      applyStimulus(9, 0, 0, 1'b0, 0, -1, "afterInterfere");

      start = 1'b1;
      action = 4'd5;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checkIdle($sformatf("badAction%0d", i));
         @(negedge clk);
      end

      applyStimulus(6, 1, 1, 1'b1, 8'h6B, -1, "sameCycleWrite");

      // Abort a frame during data bit 4, then confirm the cleared matrix and a clean restart.
      writeCell(0, 1, 8'h96);
      start = 1'b1;
      action = 4'd6;
      row = 1'b0;
      col = 2'd1;
      @(negedge clk);
      start = 1'b0;
      repeat (DIV * 5) @(negedge clk);
      for (int k = 0; k < 3; k++) checkOutput($sformatf("preAbort dut%0d busy", k), busyV[k], 1);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      clearModel();
      checkIdle("abort");
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checkIdle($sformatf("postAbort%0d", i));
      end
      applyStimulus(7, 0, 0, 1'b0, 0, -1, "clearedRow");
      writeCell(0, 1, 8'h5A);
      applyStimulus(6, 0, 1, 1'b0, 0, -1, "restart");

      for (int it = 0; it < 24; it++) begin
         nW = $urandom_range(0, 2);
         for (int j = 0; j < nW; j++) begin
            writeCell($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 255));
         end
         act = $urandom_range(6, 9);
         r = $urandom_range(0, 1);
         c = $urandom_range(0, 3);
         applyStimulus(act, r, c, ($urandom_range(0, 3) == 0), $urandom_range(0, 255),
                       ($urandom_range(0, 2) == 0) ? $urandom_range(2, 20) : -1,
                       $sformatf("rand%0d", it));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule

// File: doc/matrix_transmitter.md
Name: matrix_transmitter

Overview:
- Serial UART-style transmitter for the 2x4 cell matrix, W bits per cell. It is the sending end of the matrix link whose receiving side takes actions 2-5.
- Holds a local 2x4 matrix loaded through a write port. On a start request it serialises one cell, one row, one column or the whole matrix into a single frame on tx.
- Framing: one start bit, cell data, optional message parity, stop bit.

Parameters:
- W, 8, bits per cell.
- DIV, 3, clk cycles per serial bit (>=1).
- PAR, 0, parity mode: 0 none; 1 even (parity bit = XOR of all data bits); 2 odd (inverted XOR).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-low (asserted when 0, sampled on rising clk).
- we  in  1  matrix write enable.
- row  in  1  row select for write and for actions 6/7.
- col  in  [0:1]  column select for write and for actions 6/8.
- w_cell  in  W  write data.
- action  in  4  6 = cell[row][col]; 7 = row `row`; 8 = column `col`; 9 = whole matrix.
- start  in  1  transmit request, single-cycle qualifier.
- tx  out  1  serial line, idle high.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse after the last stop bit.

Behaviour:
- Reset (rst=0 at clk edge):
  - All matrix cells <= 0, tx <= 1, busy <= 0, done <= 0.
  - Any frame in progress is aborted immediately; tx returns high on the next cycle.
- Write: when we=1 and busy=0, matrix[row][col] <= w_cell. A write while busy=1 is ignored.
- Accept: start=1, busy=0 and action in 6..9.
  - row, col and action are latched. busy=1 and tx=0 (start bit) from the next cycle.
  - start with any other action value is ignored.
  - If we and start occur in the same cycle, the write lands first and the frame uses the new value.
- Cell order: row-major, with col incrementing before row.
  - action 6: one cell.
  - action 7: [row][0..3].
  - action 8: [0][col], [1][col].
  - action 9: [0][0..3], then [1][0..3].
  - N = 1, 4, 2 or 8 cells respectively.
- Frame: start(0), then N*W data bits with each cell LSB first, then parity bit if PAR!=0, then stop(1).
  - Every bit holds tx for exactly DIV cycles.
  - Frame length: (2 + N*W + (PAR!=0)) * DIV cycles from the first tx=0 cycle to the end of the stop bit.
- FSM: IDLE -> START -> DATA -> (PARITY if PAR!=0) -> STOP -> IDLE.
  - A divider counter 0..DIV-1 advances the state or bit at DIV-1.
  - DATA: bit index 0..W-1; at W-1 move to the next cell in order, or leave DATA after the last cell.
- Parity: accumulator cleared at accept and XORed with each transmitted data bit.
- End of STOP: busy <= 0 and done <= 1 for one cycle in that same cycle; tx stays 1.
  - A new start may be accepted in the cycle busy is seen 0.
  - Back-to-back frames are separated by at least one idle cycle.
- Mid-frame: the latched row/col/action are used for the whole frame, so input changes have no effect. start while busy is ignored.

Optional Feature:
- Macro TX_TWO_STOP_EN.
- Defined: STOP lasts 2*DIV cycles (two stop bits) and frame length grows by DIV.
- Undefined: single stop bit as above.
- done timing is relative to the end of the final stop bit in both cases.

Test Plan:
- Reset/idle: rst=0 for 2 cycles, then release -> tx=1, busy=0, done=0; all cells read back as 0 via an action-9 frame of 64 zero data bits.
- Single cell, W=8, DIV=3, PAR=0: write [1][2]=0xA5, start with action=6, row=1, col=2 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 3 cycles; busy high 30 cycles; done pulses once.
- Row with even parity (PAR=1): row0 = 0x01,0x02,0x04,0x00, action=7 -> 32 data bits LSB first per cell, parity bit 1, stop 1; frame length 35*DIV cycles.
- Column with odd parity (PAR=2): [0][3]=0xFF, [1][3]=0x0F, action=8 -> parity bit 1 (XOR=0, inverted); cell order [0][3] then [1][3].
- Interference: during an action-9 frame, pulse we (w_cell=0x3C) and start with action=6 -> matrix unchanged, frame unchanged, no second frame; an invalid action 5 while idle -> busy stays 0.
- Reset mid-frame: assert rst during DATA bit 4 -> next cycle tx=1, busy=0, no done pulse; a subsequent action-6 frame is correct from its start bit.
